// File: rtl/sound_latch_bridge.sv
// Byte mailbox between the 68000 main CPU and the Z80 sound CPU.
// Also generates the Z80 NMI pulse and tracks per-direction status.
module sound_latch_bridge #(
    parameter int NMI_PULSE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m68k_latch_cs,
    input  logic        z80_latch_read_cs,
    input  logic        m68k_rw,
    input  logic [15:0] m68k_dout,
    output logic [15:0] m68k_latch_din,
    input  logic        z80_latch_cs,
    input  logic        z80_rd_n,
    input  logic        z80_wr_n,
    input  logic [7:0]  z80_dout,
    output logic [7:0]  z80_latch_din,
    output logic        z80_nmi_n,
    output logic        latch_pending,
    output logic        latch2_pending,
    output logic        latch_overrun
);

    if (NMI_PULSE < 1 || NMI_PULSE > 255) begin : g_bad_pulse
        $error("NMI_PULSE must be within 1..255");
    end

    localparam logic [7:0] PULSE_W = 8'(NMI_PULSE);

    typedef enum logic {
        S_IDLE,
        S_PULSE
    } nmi_state_t;

    nmi_state_t state_q;
    nmi_state_t state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       nmi_n_q;

    logic [7:0] latch_q;
    logic [7:0] latch2_q;
    logic       pend_q;
    logic       pend2_q;
    logic       ovr_q;

    logic w68;
    logic r68;
    logic wz;
    logic rz;
    logic w68_prev;
    logic r68_prev;
    logic wz_prev;
    logic rz_prev;
    logic w68_rise;
    logic r68_fall;
    logic wz_rise;
    logic rz_fall;

    // The low data byte of the 68k bus carries nothing for this latch.
    logic unused_dout_lo;
    assign unused_dout_lo = ^m68k_dout[7:0];

    assign w68 = m68k_latch_cs;
    assign r68 = z80_latch_read_cs & m68k_rw;
    assign wz  = z80_latch_cs & ~z80_wr_n;
    assign rz  = z80_latch_cs & ~z80_rd_n;

    assign w68_rise = w68 & ~w68_prev;
    assign r68_fall = ~r68 & r68_prev;
    assign wz_rise  = wz & ~wz_prev;
    assign rz_fall  = ~rz & rz_prev;

    // Strobe history so each bus cycle acts exactly once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w68_prev <= 1'b0;
            r68_prev <= 1'b0;
            wz_prev  <= 1'b0;
            rz_prev  <= 1'b0;
        end else begin
            w68_prev <= w68;
            r68_prev <= r68;
            wz_prev  <= wz;
            rz_prev  <= rz;
        end
    end

    // Mailbox data and status; a set on the same edge beats a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            latch_q  <= 8'h00;
            latch2_q <= 8'h00;
            pend_q   <= 1'b0;
            pend2_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (w68_rise) begin
                latch_q <= m68k_dout[15:8];
            end
            if (w68_rise && pend_q) begin
                ovr_q <= 1'b1;
            end
            if (w68_rise) begin
                pend_q <= 1'b1;
            end else if (rz_fall) begin
                pend_q <= 1'b0;
            end
            if (wz_rise) begin
                latch2_q <= z80_dout;
            end
            if (wz_rise) begin
                pend2_q <= 1'b1;
            end else if (r68_fall) begin
                pend2_q <= 1'b0;
            end
        end
    end

    // NMI pulse state register; the output follows the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            nmi_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nmi_n_q <= (state_d == S_IDLE);
        end
    end

    // NMI next state: a 68k write (re)loads the width counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (w68_rise) begin
            state_d = S_PULSE;
            cnt_d   = PULSE_W;
        end else if (state_q == S_PULSE) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                state_d = S_IDLE;
            end
        end
    end

    assign m68k_latch_din = {latch2_q, 8'h00};
    assign z80_latch_din  = latch_q;
    assign z80_nmi_n      = nmi_n_q;
    assign latch_pending  = pend_q;
    assign latch2_pending = pend2_q;
    assign latch_overrun  = ovr_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Bench for sound_latch_bridge: transaction-level model feeds a
// scoreboard queue that a negedge monitor drains and compares.
`timescale 1ns/1ps
module tb_sound_latch_bridge;

    localparam int NMI_PULSE = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m68k_latch_cs;
    logic        z80_latch_read_cs;
    logic        m68k_rw;
    logic [15:0] m68k_dout;
    logic [15:0] m68k_latch_din;
    logic        z80_latch_cs;
    logic        z80_rd_n;
    logic        z80_wr_n;
    logic [7:0]  z80_dout;
    logic [7:0]  z80_latch_din;
    logic        z80_nmi_n;
    logic        latch_pending;
    logic        latch2_pending;
    logic        latch_overrun;

    always #5 clk = ~clk;

    sound_latch_bridge #(.NMI_PULSE(NMI_PULSE)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m68k_latch_cs    (m68k_latch_cs),
        .z80_latch_read_cs(z80_latch_read_cs),
        .m68k_rw          (m68k_rw),
        .m68k_dout        (m68k_dout),
        .m68k_latch_din   (m68k_latch_din),
        .z80_latch_cs     (z80_latch_cs),
        .z80_rd_n         (z80_rd_n),
        .z80_wr_n         (z80_wr_n),
        .z80_dout         (z80_dout),
        .z80_latch_din    (z80_latch_din),
        .z80_nmi_n        (z80_nmi_n),
        .latch_pending    (latch_pending),
        .latch2_pending   (latch2_pending),
        .latch_overrun    (latch_overrun)
    );

    typedef struct {
        logic [7:0] latch;
        logic [7:0] latch2;
        logic       nmi_n;
        logic       pend;
        logic       pend2;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_n  = 0;

    logic [7:0] m_latch  = 8'h00;
    logic [7:0] m_latch2 = 8'h00;
    logic       m_pend   = 1'b0;
    logic       m_pend2  = 1'b0;
    logic       m_ovr    = 1'b0;
    longint     edge_n    = 0;
    longint     nmi_until = 0;

    logic       ev_w68     = 1'b0;
    logic       ev_rz_end  = 1'b0;
    logic       ev_wz      = 1'b0;
    logic       ev_r68_end = 1'b0;
    logic [7:0] ev_wdata   = 8'h00;
    logic [7:0] ev_zdata   = 8'h00;

    // One clock edge: apply the bus events issued for it to the model.
    task automatic step();
        exp_t e;
        logic old_pend;
        @(posedge clk);
        #1;
        edge_n++;
        if (!reset_n) begin
            m_latch   = 8'h00;
            m_latch2  = 8'h00;
            m_pend    = 1'b0;
            m_pend2   = 1'b0;
            m_ovr     = 1'b0;
            nmi_until = 0;
        end else begin
            old_pend = m_pend;
            if (ev_rz_end) m_pend = 1'b0;
            if (ev_w68) begin
                m_latch = ev_wdata;
                if (old_pend) m_ovr = 1'b1;
                m_pend = 1'b1;
                nmi_until = edge_n + NMI_PULSE;
            end
            if (ev_r68_end) m_pend2 = 1'b0;
            if (ev_wz) begin
                m_latch2 = ev_zdata;
                m_pend2  = 1'b1;
            end
        end
        e.latch  = m_latch;
        e.latch2 = m_latch2;
        e.nmi_n  = !(edge_n < nmi_until);
        e.pend   = m_pend;
        e.pend2  = m_pend2;
        e.ovr    = m_ovr;
        exp_q.push_back(e);
        ev_w68     = 1'b0;
        ev_rz_end  = 1'b0;
        ev_wz      = 1'b0;
        ev_r68_end = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobes_off();
        m68k_latch_cs     = 1'b0;
        z80_latch_read_cs = 1'b0;
        m68k_rw           = 1'b1;
        z80_latch_cs      = 1'b0;
        z80_rd_n          = 1'b1;
        z80_wr_n          = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            m68k_latch_cs     = 1'($urandom);
            z80_latch_read_cs = 1'($urandom);
            m68k_rw           = 1'($urandom);
            z80_latch_cs      = 1'($urandom);
            z80_rd_n          = 1'($urandom);
            z80_wr_n          = 1'($urandom);
            m68k_dout         = 16'($urandom);
            z80_dout          = 8'($urandom);
            step();
        end
        strobes_off();
        reset_n = 1'b1;
    endtask

    task automatic m68k_write(input logic [15:0] d, input int len);
        m68k_dout     = d;
        m68k_latch_cs = 1'b1;
        ev_w68        = 1'b1;
        ev_wdata      = d[15:8];
        idle(len);
        m68k_latch_cs = 1'b0;
        step();
    endtask

    task automatic z80_read(input int len);
        z80_latch_cs = 1'b1;
        z80_rd_n     = 1'b0;
        idle(len);
        z80_latch_cs = 1'b0;
        z80_rd_n     = 1'b1;
        ev_rz_end    = 1'b1;
        step();
    endtask

    task automatic z80_write(input logic [7:0] d, input int len);
        z80_dout     = d;
        z80_latch_cs = 1'b1;
        z80_wr_n     = 1'b0;
        ev_wz        = 1'b1;
        ev_zdata     = d;
        idle(len);
        z80_latch_cs = 1'b0;
        z80_wr_n     = 1'b1;
        step();
    endtask

    task automatic m68k_read(input int len, input logic rw);
        z80_latch_read_cs = 1'b1;
        m68k_rw           = rw;
        idle(len);
        z80_latch_read_cs = 1'b0;
        m68k_rw           = 1'b1;
        ev_r68_end        = rw;
        step();
    endtask

    // Z80 read ends on the very edge a 68k write begins.
    task automatic read_end_with_write(input logic [15:0] d,
                                       input int rlen);
        z80_latch_cs = 1'b1;
        z80_rd_n     = 1'b0;
        idle(rlen);
        z80_latch_cs  = 1'b0;
        z80_rd_n      = 1'b1;
        ev_rz_end     = 1'b1;
        m68k_dout     = d;
        m68k_latch_cs = 1'b1;
        ev_w68        = 1'b1;
        ev_wdata      = d[15:8];
        step();
        m68k_latch_cs = 1'b0;
        step();
    endtask

    // 68k read of latch2 ends on the edge a Z80 write begins.
    task automatic r68_end_with_wz(input logic [7:0] d, input int rlen);
        z80_latch_read_cs = 1'b1;
        m68k_rw           = 1'b1;
        idle(rlen);
        z80_latch_read_cs = 1'b0;
        ev_r68_end        = 1'b1;
        z80_dout          = d;
        z80_latch_cs      = 1'b1;
        z80_wr_n          = 1'b0;
        ev_wz             = 1'b1;
        ev_zdata          = d;
        step();
        z80_latch_cs = 1'b0;
        z80_wr_n     = 1'b1;
        step();
    endtask

    // Strobes that must not count as any bus cycle.
    task automatic noise(input int len);
        z80_latch_cs      = 1'b1;
        z80_latch_read_cs = 1'b1;
        m68k_rw           = 1'b0;
        idle(len);
        strobes_off();
        step();
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %h expected %h",
                     name, mon_n, act, exp);
        end
    endtask

    // Monitor: compare each registered snapshot against the model.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mon_n++;
            chk("z80_latch_din", {8'h00, z80_latch_din}, {8'h00, e.latch});
            chk("m68k_latch_din", m68k_latch_din, {e.latch2, 8'h00});
            chk("z80_nmi_n", {15'd0, z80_nmi_n}, {15'd0, e.nmi_n});
            chk("latch_pending", {15'd0, latch_pending}, {15'd0, e.pend});
            chk("latch2_pending", {15'd0, latch2_pending},
                {15'd0, e.pend2});
            chk("latch_overrun", {15'd0, latch_overrun}, {15'd0, e.ovr});
        end
    end

    initial begin
        strobes_off();
        m68k_dout = 16'h0000;
        z80_dout  = 8'h00;
        reset_n   = 1'b0;

        do_reset(3);
        idle(2);

        m68k_write(16'hA55A, 10);
        idle(12);
        z80_read(4);
        idle(3);
        m68k_write(16'h3C00, 2);
        idle(4);
        m68k_write(16'h3C00, 3);
        idle(20);

        z80_write(8'h7E, 3);
        idle(2);
        m68k_read(3, 1'b0);
        idle(2);
        m68k_read(2, 1'b1);
        idle(2);

        do_reset(1);
        m68k_write(16'h1100, 1);
        idle(3);
        m68k_write(16'h2200, 1);
        idle(24);

        m68k_write(16'h5500, 1);
        idle(1);
        do_reset(1);
        idle(20);

        m68k_write(16'h6600, 1);
        idle(2);
        read_end_with_write(16'h7700, 3);
        idle(18);
        do_reset(1);
        read_end_with_write(16'h8800, 2);
        idle(18);
        z80_write(8'h12, 1);
        r68_end_with_wz(8'h34, 2);
        idle(3);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: m68k_write(16'($urandom), int'($urandom_range(1, 6)));
                1: z80_read(int'($urandom_range(1, 5)));
                2: z80_write(8'($urandom), int'($urandom_range(1, 5)));
                3: m68k_read(int'($urandom_range(1, 5)), 1'($urandom));
                4: noise(int'($urandom_range(1, 4)));
                5: read_end_with_write(16'($urandom),
                                       int'($urandom_range(1, 4)));
                default: r68_end_with_wz(8'($urandom),
                                         int'($urandom_range(1, 4)));
            endcase
            idle(int'($urandom_range(0, 18)));
            if (i % 20 == 19) do_reset(2);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots left, expected 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
